// File: rtl/commit_monitor.sv
`timescale 1ns/1ps
// commit_monitor: write-back retirement monitor.
// Classifies ebreak retirement as GOOD/BAD trap, detects no-retire deadlock
// through a watchdog, counts RUN cycles and real retirements, and keeps a
// ring buffer of the most recent retired PCs with a registered read port.
module commit_monitor #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned WDOG_W      = 16,
  parameter int unsigned WDOG_LIMIT  = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           retire_valid,
  input  logic [XLEN-1:0]                retire_pc,
  input  logic [31:0]                    retire_inst,
  input  logic                           retire_ebreak,
  input  logic [XLEN-1:0]                a0,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
  output logic [1:0]                     status,
  output logic                           halted,
  output logic                           halt_pulse,
  output logic [XLEN-1:0]                halt_pc,
  output logic [63:0]                    cycle_count,
  output logic [63:0]                    retire_count
);

  localparam int unsigned       IW      = $clog2(TRACE_DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;
  localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(WDOG_LIMIT);
  localparam logic [IW:0]       DEPTH_C = (IW+1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_GOOD    = 2'b01,
    ST_BAD     = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e            state_q;
  logic              halted_q;
  logic              halt_pulse_q;
  logic [XLEN-1:0]   halt_pc_q;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [63:0]       retire_q, retire_d;
  logic [IW-1:0]     wptr_q, wptr_d;
  logic [IW:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic [XLEN-1:0]   rd_pc_q, rd_pc_d;
  logic [XLEN-1:0]   trace_q [TRACE_DEPTH];

  logic              in_run;
  logic              real_ret;
  logic              do_ret;
  logic              wdog_hit;
  logic [WDOG_W-1:0] wdog_inc;
  logic [IW-1:0]     rd_slot;

  // Retirement qualification and watchdog limit detection
  always_comb begin
    in_run   = (state_q == ST_RUN);
    real_ret = retire_valid && (retire_inst != NOP);
    do_ret   = in_run && real_ret;
    wdog_inc = wdog_q + WDOG_W'(1);
    wdog_hit = in_run && !real_ret && (wdog_inc == LIMIT);
  end

  // Next-state for counters, watchdog and trace pointer; all hold once halted
  always_comb begin
    wdog_d    = wdog_q;
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    last_pc_d = last_pc_q;
    if (in_run) begin
      cycle_d = cycle_q + 64'd1;
      if (real_ret) begin
        retire_d  = retire_q + 64'd1;
        wptr_d    = wptr_q + IW'(1);
        cnt_d     = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + (IW+1)'(1);
        last_pc_d = retire_pc;
        wdog_d    = '0;
      end else begin
        wdog_d = wdog_inc;
      end
    end
  end

  // Trace readout: index 0 is the newest entry, out-of-range indices read 0
  always_comb begin
    rd_slot = wptr_q - IW'(1) - trace_rd_idx;
    rd_pc_d = ({1'b0, trace_rd_idx} < cnt_q) ? trace_q[rd_slot] : '0;
  end

  // Counter, watchdog, pointer and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      last_pc_q <= '0;
      rd_pc_q   <= '0;
    end else begin
      wdog_q    <= wdog_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
      rd_pc_q   <= rd_pc_d;
    end
  end

  // Trace ring storage, written on each real retirement in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
        trace_q[i] <= '0;
      end
    end else if (do_ret) begin
      trace_q[wptr_q] <= retire_pc;
    end
  end

  // Halt FSM: ebreak retirement takes priority over the watchdog limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      halt_pulse_q <= 1'b0;
      halt_pc_q    <= '0;
    end else begin
      halt_pulse_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (real_ret && retire_ebreak) begin
            state_q      <= (a0 == '0) ? ST_GOOD : ST_BAD;
            halted_q     <= 1'b1;
            halt_pulse_q <= 1'b1;
            halt_pc_q    <= retire_pc;
          end else if (wdog_hit) begin
            state_q      <= ST_TIMEOUT;
            halted_q     <= 1'b1;
            halt_pulse_q <= 1'b1;
            halt_pc_q    <= last_pc_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign status       = state_q;
  assign halted       = halted_q;
  assign halt_pulse   = halt_pulse_q;
  assign halt_pc      = halt_pc_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign trace_cnt    = cnt_q;
  assign trace_rd_pc  = rd_pc_q;

endmodule
